pipe_stage_reg: RTL and testbench
=================================

// Module: pipe_stage_reg
// PURPOSE
//  Generic inter-stage pipeline register for the 5-stage CPU. Successor to the fixed MEM/WB latch.
//  Registers every field: control, N data words and rd address. Adds valid/ready flow control,
//  synchronous flush and an optional 2-entry skid buffer, so a downstream stall never drops data
//  and never combinationally loops ready. Instanced as IF/ID, ID/EX, EX/MEM and MEM/WB.
// PARAMETERS
//  DATA_W    32  width of one data word (ALU result, mem read data, ...)
//  NUM_DATA  2   number of data words carried (MEM/WB: MemRdata, ALUres)
//  CTRL_W    2   control bits carried (MEM/WB: {WBSrc, WB})
//  ADDR_W    5   destination register address width
//  SKID      1   1: 2-entry skid buffer, registered ready_o; 0: single entry, comb ready_o
// PORTS
//  clk_i      in   1                 clock, all state on posedge
//  rst_i      in   1                 asynchronous reset, active-low
//  flush_i    in   1                 synchronous flush (branch/exception), kills all held entries
//  valid_i    in   1                 upstream entry valid
//  ready_o    out  1                 stage can accept this cycle
//  ctrl_i     in   CTRL_W            upstream control bits
//  data_i     in   NUM_DATA*DATA_W   packed data words, word k at [k*DATA_W +: DATA_W]
//  rd_addr_i  in   ADDR_W            destination register
//  valid_o    out  1                 downstream entry valid
//  ready_i    in   1                 downstream accepts this cycle
//  ctrl_o     out  CTRL_W            registered control, forced 0 when valid_o=0
//  data_o     out  NUM_DATA*DATA_W   registered data
//  rd_addr_o  out  ADDR_W            registered destination register
//  stall_cnt_o out 16                cycles with valid_o=1 and ready_i=0, saturating
// BEHAVIOUR
//  - Reset (rst_i=0, async): both entries invalid, data/ctrl/addr regs 0, ready_o=1, valid_o=0,
//    stall_cnt_o=0. Every output takes its reset value immediately, independent of clk_i.
//  - Accept = valid_i & ready_o; emit = valid_o & ready_i. Latency is 1 cycle: input accepted at
//    edge n is on the outputs after edge n when the stage was empty or draining.
//  - All outputs come straight from flops; no input-to-output combinational path on data/ctrl.
//  - ctrl_o = main_ctrl & {CTRL_W{valid_o}}, so a bubble never asserts WB/MemWrite.
//  - SKID=1: main entry M drives outputs, skid entry S. ready_o = ~S.valid (registered).
//    States by {S.valid,M.valid}: EMPTY(00), ONE(01), FULL(11).
//    EMPTY: accept -> load M, go ONE.
//    ONE: accept&emit -> load M, stay ONE; emit only -> EMPTY; accept only -> load S, go FULL;
//         neither -> hold.
//    FULL: ready_o=0; emit -> S moves to M, go ONE; else hold.
//  - SKID=0: M only, ready_o = ready_i | ~M.valid (combinational). Accept loads M, emit w/o
//    accept clears M.valid.
//  - flush_i=1 at an edge: M.valid=S.valid=0 next cycle, overrides any accept that cycle.
//    Data regs need not clear. ready_o=1 the next cycle.
//  - valid_i with ready_o=0: no state change; upstream must hold its payload stable.
//  - stall_cnt_o: +1 per cycle with valid_o & ~ready_i, saturates at 16'hFFFF, cleared
//    only by reset.
// STRUCTURE
//  - Shared package cpu_pipe_pkg: CTRL_W/ADDR_W defaults, MEM/WB ctrl bit indices (CTRL_WB=0,
//    CTRL_WBSRC=1), state encoding localparams ST_EMPTY/ST_ONE/ST_FULL.
//  - One sub-module: pipe_entry (valid bit plus payload register with load and clear).
//    Instance it twice for SKID=1 and once for SKID=0 (generate).
// TESTING
//  1. Reset mid-traffic: assert rst_i low between edges -> valid_o=0, ready_o=1, ctrl_o=0,
//     stall_cnt_o=0 at once.
//  2. Stream, ready_i=1: 4 entries data0=0x11..0x44, rd=1..4 -> same order out, 1-cycle latency,
//     ready_o stays 1.
//  3. Skid, SKID=1: ready_i=0 while sending 0xA,0xB -> ready_o=0 after 2nd accept, stall_cnt
//     counts. ready_i=1 -> 0xA then 0xB, none lost or duplicated.
//  4. Flush in FULL with valid_i=1 (0xC): next cycle valid_o=0, ctrl_o=0. 0xC never appears.
//     ready_o=1.
//  5. Bubble gating: valid_i=0, ctrl_i=2'b11 -> ctrl_o=2'b00 every cycle.
//  6. SKID=0, NUM_DATA=3, DATA_W=64: backpressure 3 cycles -> ready_o tracks ready_i,
//     payload intact.

Source files
------------

// File: rtl/cpu_pipe_pkg.sv
// Shared definitions for the CPU inter-stage pipeline registers.
// Holds width defaults, MEM/WB control bit positions and the stage occupancy encoding.
package cpu_pipe_pkg;

  localparam int CTRL_W_DEF = 2;
  localparam int ADDR_W_DEF = 5;

  // MEM/WB control bit positions within ctrl
  localparam int CTRL_WB    = 0;
  localparam int CTRL_WBSRC = 1;

  // Occupancy encoding {skid.valid, main.valid}
  localparam logic [1:0] ST_EMPTY = 2'b00;
  localparam logic [1:0] ST_ONE   = 2'b01;
  localparam logic [1:0] ST_FULL  = 2'b11;

  localparam logic [15:0] STALL_MAX = 16'hFFFF;

endpackage

// File: rtl/pipe_entry.sv
// One pipeline slot: a valid bit plus its payload register.
// Clear wins over load; the payload only changes on an effective load.
module pipe_entry #(
  parameter int PAY_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             clr_i,
  input  logic [PAY_W-1:0] pay_i,
  output logic             vld_o,
  output logic [PAY_W-1:0] pay_o
);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      vld_o <= 1'b0;
      pay_o <= '0;
    end else begin
      if (clr_i) begin
        vld_o <= 1'b0;
      end else if (load_i) begin
        vld_o <= 1'b1;
        pay_o <= pay_i;
      end
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register with valid/ready handshake, flush and optional skid slot.
// All outputs are driven from flops; ctrl_o is gated so a bubble never carries live control.
module pipe_stage_reg
  import cpu_pipe_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int NUM_DATA = 2,
  parameter int CTRL_W   = CTRL_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int SKID     = 1
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic                       valid_i,
  output logic                       ready_o,
  input  logic [CTRL_W-1:0]          ctrl_i,
  input  logic [NUM_DATA*DATA_W-1:0] data_i,
  input  logic [ADDR_W-1:0]          rd_addr_i,
  output logic                       valid_o,
  input  logic                       ready_i,
  output logic [CTRL_W-1:0]          ctrl_o,
  output logic [NUM_DATA*DATA_W-1:0] data_o,
  output logic [ADDR_W-1:0]          rd_addr_o,
  output logic [15:0]                stall_cnt_o
);

  localparam int PAY_W = CTRL_W + ADDR_W + NUM_DATA*DATA_W;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == STALL_MAX) ? v : v + 16'd1;
  endfunction

  logic             accept;
  logic             emit;
  logic             m_vld;
  logic [PAY_W-1:0] m_pay;
  logic [PAY_W-1:0] in_pay;
  logic [CTRL_W-1:0] m_ctrl;

  assign in_pay = {ctrl_i, rd_addr_i, data_i};
  assign accept = valid_i & ready_o;
  assign emit   = m_vld & ready_i;

  generate
    if (SKID != 0) begin : g_skid
      logic             s_vld;
      logic [PAY_W-1:0] s_pay;
      logic             m_load, m_clr, s_load, s_clr;
      logic [PAY_W-1:0] m_src;

      always_comb begin
        m_load = 1'b0;
        m_clr  = 1'b0;
        s_load = 1'b0;
        s_clr  = 1'b0;
        m_src  = in_pay;
        case ({s_vld, m_vld})
          ST_EMPTY: m_load = accept;
          ST_ONE: begin
            if (accept) begin
              if (emit) m_load = 1'b1;
              else      s_load = 1'b1;
            end else if (emit) begin
              m_clr = 1'b1;
            end
          end
          ST_FULL: begin
            if (emit) begin
              m_load = 1'b1;
              m_src  = s_pay;
              s_clr  = 1'b1;
            end
          end
          // skid-only occupancy cannot arise; drop it to recover
          default: s_clr = 1'b1;
        endcase
        if (flush_i) begin
          m_clr = 1'b1;
          s_clr = 1'b1;
        end
      end

      pipe_entry #(.PAY_W(PAY_W)) u_main (
        .clk_i (clk_i), .rst_i (rst_i), .load_i (m_load), .clr_i (m_clr),
        .pay_i (m_src), .vld_o (m_vld), .pay_o (m_pay)
      );

      pipe_entry #(.PAY_W(PAY_W)) u_skid (
        .clk_i (clk_i), .rst_i (rst_i), .load_i (s_load), .clr_i (s_clr),
        .pay_i (in_pay), .vld_o (s_vld), .pay_o (s_pay)
      );

      assign ready_o = ~s_vld;
    end else begin : g_single
      logic m_load, m_clr;

      assign m_load = accept;
      assign m_clr  = flush_i | (emit & ~accept);

      pipe_entry #(.PAY_W(PAY_W)) u_main (
        .clk_i (clk_i), .rst_i (rst_i), .load_i (m_load), .clr_i (m_clr),
        .pay_i (in_pay), .vld_o (m_vld), .pay_o (m_pay)
      );

      assign ready_o = ready_i | ~m_vld;
    end
  endgenerate

  // Output stage: straight from the main slot
  assign {m_ctrl, rd_addr_o, data_o} = m_pay;
  assign ctrl_o  = m_ctrl & {CTRL_W{m_vld}};
  assign valid_o = m_vld;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt_o <= '0;
    end else if (m_vld && !ready_i) begin
      stall_cnt_o <= sat_inc(stall_cnt_o);
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: skid variant (A) and single-slot 3x64 variant (B).
// A scoreboard queue per instance holds accepted payloads in order until they are emitted.
module tb_pipe_stage_reg;

  logic clk;
  logic rst_n;

  logic         a_flush, a_valid, a_ready, a_ro, a_vo;
  logic [1:0]   a_ctrl, a_co;
  logic [63:0]  a_data, a_do;
  logic [4:0]   a_rd, a_rdo;
  logic [15:0]  a_sco;

  logic         b_flush, b_valid, b_ready, b_ro, b_vo;
  logic [1:0]   b_ctrl, b_co;
  logic [191:0] b_data, b_do;
  logic [4:0]   b_rd, b_rdo;
  logic [15:0]  b_sco;

  logic [70:0]  qa[$];
  logic [198:0] qb[$];
  logic [15:0]  a_stall_exp, b_stall_exp;

  int errs;
  int checks;

  pipe_stage_reg #(.DATA_W(32), .NUM_DATA(2), .CTRL_W(2), .ADDR_W(5), .SKID(1)) u_dut_a (
    .clk_i(clk), .rst_i(rst_n), .flush_i(a_flush), .valid_i(a_valid), .ready_o(a_ro),
    .ctrl_i(a_ctrl), .data_i(a_data), .rd_addr_i(a_rd), .valid_o(a_vo), .ready_i(a_ready),
    .ctrl_o(a_co), .data_o(a_do), .rd_addr_o(a_rdo), .stall_cnt_o(a_sco)
  );

  pipe_stage_reg #(.DATA_W(64), .NUM_DATA(3), .CTRL_W(2), .ADDR_W(5), .SKID(0)) u_dut_b (
    .clk_i(clk), .rst_i(rst_n), .flush_i(b_flush), .valid_i(b_valid), .ready_o(b_ro),
    .ctrl_i(b_ctrl), .data_i(b_data), .rd_addr_i(b_rd), .valid_o(b_vo), .ready_i(b_ready),
    .ctrl_o(b_co), .data_o(b_do), .rd_addr_o(b_rdo), .stall_cnt_o(b_sco)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at edge+1 with inputs already driven; returns whether the stage accepted.
  task automatic cycle_a(output bit acc);
    #1;
    chk("a_valid_o", a_vo, qa.size() != 0);
    chk("a_ready_o", a_ro, qa.size() < 2);
    if (qa.size() == 0) chk("a_bubble_ctrl", a_co, 2'b00);
    else                chk("a_payload", {a_co, a_rdo, a_do}, qa[0]);
    if (a_vo && a_ready && qa.size() != 0) void'(qa.pop_front());
    if (a_vo && !a_ready && a_stall_exp != 16'hFFFF) a_stall_exp++;
    acc = a_valid && a_ro && !a_flush;
    if (a_flush) qa.delete();
    else if (a_valid && a_ro) qa.push_back({a_ctrl, a_rd, a_data});
    @(posedge clk);
    #1;
    chk("a_stall_cnt", a_sco, a_stall_exp);
  endtask

  task automatic cycle_b(output bit acc);
    #1;
    chk("b_valid_o", b_vo, qb.size() != 0);
    chk("b_ready_o", b_ro, b_ready || (qb.size() == 0));
    if (qb.size() == 0) chk("b_bubble_ctrl", b_co, 2'b00);
    else                chk("b_payload", {b_co, b_rdo, b_do}, qb[0]);
    if (b_vo && b_ready && qb.size() != 0) void'(qb.pop_front());
    if (b_vo && !b_ready && b_stall_exp != 16'hFFFF) b_stall_exp++;
    acc = b_valid && b_ro && !b_flush;
    if (b_flush) qb.delete();
    else if (b_valid && b_ro) qb.push_back({b_ctrl, b_rd, b_data});
    @(posedge clk);
    #1;
    chk("b_stall_cnt", b_sco, b_stall_exp);
  endtask

  task automatic send_a(input logic [7:0] tag, input logic [4:0] rd, input logic [1:0] ctrl);
    a_valid = 1'b1;
    a_data  = {24'hC0FFEE, tag, 24'h0, tag};
    a_rd    = rd;
    a_ctrl  = ctrl;
  endtask

  initial begin
    bit acc;
    int idx;
    errs = 0; checks = 0;
    a_stall_exp = '0; b_stall_exp = '0;
    rst_n = 1'b0;
    a_flush = 0; a_valid = 0; a_ready = 1; a_ctrl = '0; a_data = '0; a_rd = '0;
    b_flush = 0; b_valid = 0; b_ready = 1; b_ctrl = '0; b_data = '0; b_rd = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid_o", a_vo, 1'b0);
    chk("rst_ready_o", a_ro, 1'b1);
    chk("rst_stall", a_sco, 16'h0);
    chk("rst_b_valid_o", b_vo, 1'b0);
    rst_n = 1'b1;

    // Streaming with ready_i=1: four entries, one-cycle latency
    for (int i = 0; i < 4; i++) begin
      send_a(8'(8'h11 * (i + 1)), 5'(i + 1), 2'(i));
      cycle_a(acc);
      chk("stream_acc", acc, 1'b1);
    end
    a_valid = 1'b0;
    repeat (2) cycle_a(acc);

    // Skid: two accepts under backpressure, then drain in order
    a_ready = 1'b0;
    send_a(8'h0A, 5'd10, 2'b01); cycle_a(acc);
    send_a(8'h0B, 5'd11, 2'b10); cycle_a(acc);
    a_valid = 1'b0;
    repeat (2) cycle_a(acc);
    a_ready = 1'b1;
    repeat (3) cycle_a(acc);

    // Flush while full with an incoming entry
    a_ready = 1'b0;
    send_a(8'h0D, 5'd13, 2'b11); cycle_a(acc);
    send_a(8'h0E, 5'd14, 2'b11); cycle_a(acc);
    send_a(8'h0C, 5'd12, 2'b11);
    a_flush = 1'b1; cycle_a(acc);
    a_flush = 1'b0; a_valid = 1'b0;
    cycle_a(acc);
    a_ready = 1'b1;
    repeat (2) cycle_a(acc);

    // Flush in single-occupancy state overrides a would-be accept
    a_ready = 1'b0;
    send_a(8'h0F, 5'd15, 2'b01); cycle_a(acc);
    send_a(8'h77, 5'd7, 2'b11);
    a_flush = 1'b1; cycle_a(acc);
    a_flush = 1'b0; a_valid = 1'b0; a_ready = 1'b1;
    repeat (2) cycle_a(acc);

    // Bubble gating: live ctrl bits on an invalid input
    a_valid = 1'b0; a_ctrl = 2'b11;
    for (int i = 0; i < 3; i++) begin
      a_ready = 1'(i & 1);
      cycle_a(acc);
    end

    // Single-slot wide variant with three cycles of backpressure
    idx = 0;
    for (int t = 0; t < 12; t++) begin
      b_ready = !(t >= 2 && t <= 4);
      b_valid = (idx < 6);
      b_data  = {64'hB000_0000_0000_0000 | 64'(idx*3+2), 64'hA5A5_0000_0000_0000 | 64'(idx*3+1),
                 64'h1234_0000_0000_0000 | 64'(idx*3)};
      b_rd    = 5'(idx + 20);
      b_ctrl  = 2'(idx);
      cycle_b(acc);
      if (acc) idx++;
    end
    b_valid = 1'b0;
    chk("b_all_sent", idx, 6);

    // Asynchronous reset between edges with traffic held
    a_ready = 1'b0;
    send_a(8'h55, 5'd5, 2'b11); cycle_a(acc);
    a_valid = 1'b0;
    cycle_a(acc);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_valid_o", a_vo, 1'b0);
    chk("arst_ready_o", a_ro, 1'b1);
    chk("arst_ctrl_o", a_co, 2'b00);
    chk("arst_stall", a_sco, 16'h0);
    qa.delete();
    a_stall_exp = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    a_ready = 1'b1;
    send_a(8'h66, 5'd6, 2'b10); cycle_a(acc);
    a_valid = 1'b0;
    repeat (2) cycle_a(acc);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
